// File: rtl/vid_sampler_pkg.sv
// rtl/vid_sampler_pkg.sv - dither mode encoding and 4x4 Bayer matrix shared by the DPI sampler
package vid_sampler_pkg;

  typedef enum logic [1:0] {
    DM_NONE     = 2'd0,
    DM_BAYER    = 2'd1,
    DM_TEMPORAL = 2'd2,
    DM_RESERVED = 2'd3
  } dither_mode_e;

  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  function automatic logic [3:0] bayer_lookup(input logic [1:0] row, input logic [1:0] col);
    return BAYER4[row][col];
  endfunction

endpackage

// File: rtl/vid_async_fifo.sv
// rtl/vid_async_fifo.sv - dual-clock FIFO with Gray pointers and 2-flop pointer synchronisers
module vid_async_fifo #(
  parameter int DW = 18,
  parameter int AW = 3
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          rd_clk,
  input  logic          rd_rst,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wbin, wgray, rbin, rgray;
  logic [AW:0]   rq1, rq2, wq1, wq2;
  logic [AW:0]   wbin_nx, rbin_nx;
  logic          full, empty, push, pop;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
  assign full     = (wgray == {~rq2[AW:AW-1], rq2[AW-2:0]});
  assign empty    = (rgray == wq2);
  assign s_tready = ~full;
  assign m_tvalid = ~empty;
  assign push     = s_tvalid & ~full;
  assign pop      = m_tready & ~empty;
  assign wbin_nx  = wbin + 1'b1;
  assign rbin_nx  = rbin + 1'b1;
  assign m_tdata  = mem[rbin[AW-1:0]];

  // Storage array, written from the pixel side only.
  always_ff @(posedge wr_clk) begin
    if (push) mem[wbin[AW-1:0]] <= s_tdata;
  end

  // Write pointer advance and read-pointer synchroniser into the write domain.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin  <= '0;
      wgray <= '0;
      rq1   <= '0;
      rq2   <= '0;
    end else begin
      rq1 <= rgray;
      rq2 <= rq1;
      if (push) begin
        wbin  <= wbin_nx;
        wgray <= bin2gray(wbin_nx);
      end
    end
  end

  // Read pointer advance and write-pointer synchroniser into the read domain.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin  <= '0;
      rgray <= '0;
      wq1   <= '0;
      wq2   <= '0;
    end else begin
      wq1 <= wgray;
      wq2 <= wq1;
      if (pop) begin
        rbin  <= rbin_nx;
        rgray <= bin2gray(rbin_nx);
      end
    end
  end

endmodule

// File: rtl/vid_dither_sampler.sv
// rtl/vid_dither_sampler.sv - DPI pixel tracker, dithered quantiser and CDC into the VRAM write port
module vid_dither_sampler
  import vid_sampler_pkg::*;
#(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2,
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 8,
  parameter int ACTIVE_W = 160,
  parameter int ACTIVE_H = 144,
  parameter int Q_MUL    = 5,
  parameter int Q_SHIFT  = 4,
  parameter int FIFO_AW  = 3
) (
  input  logic                     rst,
  input  logic                     rgb_clk,
  input  logic                     rgb_de,
  input  logic                     rgb_vsync,
  input  logic [IN_BITS-1:0]       rgb_data,
  input  logic [1:0]               dither_mode,
  input  logic                     vramclk,
  output logic [X_BITS+Y_BITS-1:0] vramaddr,
  output logic [OUT_BITS-1:0]      vramdata,
  output logic                     vramwe,
  output logic                     overflow
);

  localparam int LEVELS = 2**OUT_BITS;
  localparam int ADW    = X_BITS + Y_BITS;
  localparam int DW     = ADW + OUT_BITS;
  localparam int PW     = IN_BITS + 20;
  localparam logic [X_BITS:0] W_LIM = (X_BITS+1)'(ACTIVE_W);
  localparam logic [Y_BITS:0] H_LIM = (Y_BITS+1)'(ACTIVE_H);

  logic [X_BITS-1:0]  x;
  logic [Y_BITS-1:0]  y;
  logic [1:0]         frameno;
  dither_mode_e       mode_q;
  logic               de_q, vs_q, vs_pend;
  logic               vs_rise, frame_start, in_window;
  logic [1:0]         f, brow, bcol;
  logic [Q_SHIFT-1:0] dith;

  logic               s1_valid;
  logic [X_BITS-1:0]  s1_x;
  logic [Y_BITS-1:0]  s1_y;
  logic [IN_BITS-1:0] s1_data;
  logic [Q_SHIFT-1:0] s1_dith;
  logic [PW-1:0]      prod, q;
  logic [OUT_BITS-1:0] pix;

  logic               fifo_ready, rd_valid;
  logic [DW-1:0]      rd_data;
  logic               vram_rst_q1, vram_rst;

  // A vsync edge seen while de is high is held pending and applied once de drops.
  assign vs_rise     = rgb_vsync & ~vs_q;
  assign frame_start = (vs_rise | vs_pend) & ~rgb_de;
  assign in_window   = rgb_de && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);

  // Position, frame counter and per-frame dither mode.
  always_ff @(posedge rgb_clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      frameno <= '0;
      mode_q  <= DM_NONE;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      vs_pend <= 1'b0;
    end else begin
      de_q <= rgb_de;
      vs_q <= rgb_vsync;
      if (frame_start) begin
        x       <= '0;
        y       <= '0;
        frameno <= frameno + 1'b1;
        mode_q  <= dither_mode_e'(dither_mode);
        vs_pend <= 1'b0;
      end else begin
        if (vs_rise) vs_pend <= 1'b1;
        if (rgb_de) begin
          if (x != '1) x <= x + 1'b1;
        end else if (de_q) begin
          x <= '0;
          if (y != '1) y <= y + 1'b1;
        end
      end
    end
  end

  // Temporal mode shifts the Bayer phase diagonally by the frame number.
  always_comb begin
    f    = (mode_q == DM_TEMPORAL) ? frameno : 2'd0;
    brow = y[1:0] + f;
    bcol = x[1:0] + f;
    dith = '0;
    if (mode_q != DM_NONE) dith = Q_SHIFT'(bayer_lookup(brow, bcol)) << (Q_SHIFT - 4);
  end

  // Stage 1: capture in-window pixel with its coordinates and dither term.
  always_ff @(posedge rgb_clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_data  <= '0;
      s1_dith  <= '0;
    end else begin
      s1_valid <= in_window;
      if (in_window) begin
        s1_x    <= x;
        s1_y    <= y;
        s1_data <= rgb_data;
        s1_dith <= dith;
      end
    end
  end

  // Stage 2 quantiser, wide enough that nothing is lost before the shift.
  always_comb begin
    prod = PW'(s1_data) * PW'(Q_MUL) + PW'(s1_dith);
    q    = prod >> Q_SHIFT;
    pix  = (q > PW'(LEVELS - 1)) ? OUT_BITS'(LEVELS - 1) : q[OUT_BITS-1:0];
  end

  // Sticky drop flag when stage 2 finds the FIFO full.
  always_ff @(posedge rgb_clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (s1_valid && !fifo_ready) overflow <= 1'b1;
  end

  vid_async_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .wr_clk   (rgb_clk),
    .wr_rst   (rst),
    .s_tdata  ({s1_y, s1_x, pix}),
    .s_tvalid (s1_valid),
    .s_tready (fifo_ready),
    .rd_clk   (vramclk),
    .rd_rst   (vram_rst),
    .m_tdata  (rd_data),
    .m_tvalid (rd_valid),
    .m_tready (1'b1)
  );

  // VRAM-side reset: asserts immediately, releases two vramclk edges after rst drops.
  always_ff @(posedge vramclk or posedge rst) begin
    if (rst) begin
      vram_rst_q1 <= 1'b1;
      vram_rst    <= 1'b1;
    end else begin
      vram_rst_q1 <= 1'b0;
      vram_rst    <= vram_rst_q1;
    end
  end

  // Pop one entry per vramclk while available and present it with a one-cycle write strobe.
  always_ff @(posedge vramclk or posedge vram_rst) begin
    if (vram_rst) begin
      vramwe   <= 1'b0;
      vramaddr <= '0;
      vramdata <= '0;
    end else begin
      vramwe <= rd_valid;
      if (rd_valid) begin
        vramaddr <= rd_data[DW-1:OUT_BITS];
        vramdata <= rd_data[OUT_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vid_dither_sampler.sv
// tb/tb_vid_dither_sampler.sv - scoreboard bench for the dithering DPI sampler
module tb_vid_dither_sampler;

  logic        rst;
  logic        rgb_clk = 1'b0;
  logic        rgb_de;
  logic        rgb_vsync;
  logic [3:0]  rgb_data;
  logic [1:0]  dither_mode;
  logic        vramclk = 1'b0;
  logic [15:0] vramaddr;
  logic [1:0]  vramdata;
  logic        vramwe;
  logic        overflow;

  int vram_half = 3;

  vid_dither_sampler dut (
    .rst         (rst),
    .rgb_clk     (rgb_clk),
    .rgb_de      (rgb_de),
    .rgb_vsync   (rgb_vsync),
    .rgb_data    (rgb_data),
    .dither_mode (dither_mode),
    .vramclk     (vramclk),
    .vramaddr    (vramaddr),
    .vramdata    (vramdata),
    .vramwe      (vramwe),
    .overflow    (overflow)
  );

  always #5 rgb_clk = ~rgb_clk;
  always #(vram_half) vramclk = ~vramclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [17:0] exp_q [$];
  bit          mono_mode = 1'b0;
  int          wcount = 0;
  int          prev_addr = -1;
  logic [15:0] last_addr = '0;

  int mx = 0, my = 0, mframe = 0, mmode = 0;
  int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  function automatic int exp_pix(input int d);
    int dd, f, qq;
    f = mframe % 4;
    if (mmode == 0)      dd = 0;
    else if (mmode == 2) dd = bay[(my + f) % 4][(mx + f) % 4];
    else                 dd = bay[my % 4][mx % 4];
    qq = (d * 5 + dd) >> 4;
    return (qq > 3) ? 3 : qq;
  endfunction

  // Monitor: every VRAM write is matched against the scoreboard or checked for order.
  always @(negedge vramclk) begin
    if (!rst && vramwe) begin
      logic [17:0] e;
      wcount++;
      last_addr = vramaddr;
      if (mono_mode) begin
        check("addr_increasing", int'(vramaddr) > prev_addr, 1);
        prev_addr = int'(vramaddr);
      end else begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("vramaddr", vramaddr, e[17:2]);
          check("vramdata", vramdata, e[1:0]);
        end
      end
    end
  end

  task automatic pix(input int d);
    int p;
    logic [17:0] e;
    rgb_de   = 1'b1;
    rgb_data = d[3:0];
    if (mx < 160 && my < 144 && !mono_mode) begin
      p = exp_pix(d);
      e = {8'(my), 8'(mx), 2'(p)};
      exp_q.push_back(e);
    end
    if (mx < 255) mx++;
    @(negedge rgb_clk);
  endtask

  task automatic line_end();
    rgb_de = 1'b0;
    mx = 0;
    if (my < 255) my++;
    @(negedge rgb_clk);
  endtask

  task automatic frame_start(input int m);
    dither_mode = m[1:0];
    rgb_vsync = 1'b1;
    @(negedge rgb_clk);
    rgb_vsync = 1'b0;
    @(negedge rgb_clk);
    mx = 0;
    my = 0;
    mframe++;
    mmode = m;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge rgb_clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (20) @(negedge rgb_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rgb_de = 1'b0;
    rgb_vsync = 1'b0;
    rgb_data = '0;
    dither_mode = 2'd0;
    repeat (5) @(negedge rgb_clk);
    rst = 1'b0;
    repeat (5) @(negedge vramclk);
    check("rst_vramwe", vramwe, 0);
    check("rst_vramaddr", vramaddr, 0);
    check("rst_vramdata", vramdata, 0);
    check("rst_overflow", overflow, 0);
    @(negedge rgb_clk);

    // Mode 0 straight quantisation.
    pix(11);
    pix(6);
    line_end();
    drain();

    // Mode 1 ordered dither, including row 3.
    frame_start(1);
    pix(6);
    line_end();
    pix(0); line_end();
    pix(0); line_end();
    pix(6);
    pix(15);
    line_end();
    drain();

    // Reserved mode behaves as ordered; D=15 with full-scale data saturates.
    frame_start(3);
    for (int i = 0; i < 3; i++) begin
      pix(0);
      line_end();
    end
    pix(15);
    line_end();
    drain();

    // Temporal dither over four consecutive frames.
    for (int k = 0; k < 4; k++) begin
      frame_start(2);
      pix(6);
      line_end();
      drain();
    end

    // Overlong line is clipped at the active width.
    frame_start(0);
    wcount = 0;
    for (int i = 0; i < 200; i++) pix(i % 16);
    line_end();
    drain();
    check("win_count", wcount, 160);
    check("win_last_addr", last_addr, 16'h009F);

    // Too many lines: y saturates and rows past the active height are dropped.
    frame_start(0);
    wcount = 0;
    for (int i = 0; i < 300; i++) begin
      pix(1);
      line_end();
    end
    drain();
    check("lines_count", wcount, 144);
    check("y_saturated", dut.y, 255);
    check("no_overflow", overflow, 0);

    // Slow VRAM clock with continuous de overruns the FIFO.
    vram_half = 20;
    repeat (10) @(negedge rgb_clk);
    mono_mode = 1'b1;
    prev_addr = -1;
    wcount = 0;
    frame_start(0);
    for (int i = 0; i < 100; i++) pix(5);
    line_end();
    repeat (300) @(negedge rgb_clk);
    check("overflow_set", overflow, 1);
    check("cdc_min_writes", wcount >= 8, 1);
    check("cdc_dropped", wcount < 100, 1);

    // Reset in the middle of a line flushes everything.
    prev_addr = -1;
    frame_start(0);
    for (int i = 0; i < 30; i++) pix(5);
    rst = 1'b1;
    @(negedge vramclk);
    @(negedge vramclk);
    check("midrst_vramwe", vramwe, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_vramaddr", vramaddr, 0);
    rgb_de = 1'b0;
    @(negedge rgb_clk);
    rst = 1'b0;
    wcount = 0;
    repeat (100) @(negedge rgb_clk);
    check("midrst_flushed", wcount, 0);
    check("midrst_vramwe_idle", vramwe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
